// File: rtl/ir_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ir_ctrl_pkg
//   Shared definitions for the accumulator-CPU timing/control sequencer:
//   state encoding (the encoding is the reported sequence counter value),
//   opcode constants, bus-select and ALU-op codes, control-bundle bit
//   indices and register-reference instruction bit masks.
// ---------------------------------------------------------------------------
package ir_ctrl_pkg;

  // T0..T6 encode as 0..6 so the state register doubles as scT; HALT is 7.
  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  // Opcodes, IR[14:12]
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;  // register-ref (I=0) or I/O (I=1)

  // Bus source select
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // ALU operation
  localparam logic [1:0] ALU_AND     = 2'd0;
  localparam logic [1:0] ALU_ADD     = 2'd1;
  localparam logic [1:0] ALU_PASS_DR = 2'd2;
  localparam logic [1:0] ALU_CMA     = 2'd3;

  // Bit positions inside each {CLR,INR,LD} control bundle
  localparam int CTL_LD  = 0;
  localparam int CTL_INR = 1;
  localparam int CTL_CLR = 2;

  // Register-reference micro-op masks over IR[11:0]
  localparam logic [11:0] RR_CLA = 12'h800;
  localparam logic [11:0] RR_CMA = 12'h200;
  localparam logic [11:0] RR_INC = 12'h020;
  localparam logic [11:0] RR_SPA = 12'h010;
  localparam logic [11:0] RR_SNA = 12'h008;
  localparam logic [11:0] RR_SZA = 12'h004;
  localparam logic [11:0] RR_HLT = 12'h001;

endpackage

// File: rtl/ir_op_decode.sv
// ---------------------------------------------------------------------------
// ir_op_decode
//   Purely combinational classification of the current instruction.
//   Ports:
//     ir_i         instruction word from ir_reg
//     indirect_o   I bit, IR[DATA_W-1]
//     mem_ref_o    opcode 0..6 (memory-reference)
//     reg_ref_o    opcode 7 with I=0
//     io_ref_o     opcode 7 with I=1
//     op_onehot_o  one-hot of the memory-reference opcode (zero otherwise)
//     rr_bits_o    address field, interpreted as micro-op bits for reg-ref
// ---------------------------------------------------------------------------
module ir_op_decode
  import ir_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir_i,
  output logic              indirect_o,
  output logic              mem_ref_o,
  output logic              reg_ref_o,
  output logic              io_ref_o,
  output logic [6:0]        op_onehot_o,
  output logic [ADDR_W-1:0] rr_bits_o
);

  logic [2:0] opcode;

  assign opcode      = ir_i[DATA_W-2 -: 3];
  assign indirect_o  = ir_i[DATA_W-1];
  assign mem_ref_o   = (opcode != OP_REG);
  assign reg_ref_o   = (opcode == OP_REG) && !indirect_o;
  assign io_ref_o    = (opcode == OP_REG) &&  indirect_o;
  // Shifting by 7 walks the bit off the end, so opcode 7 decodes to all zeros.
  assign op_onehot_o = 7'(1) << opcode;
  assign rr_bits_o   = ir_i[ADDR_W-1:0];

endmodule

// File: rtl/ir_ctrl_seq.sv
// ---------------------------------------------------------------------------
// ir_ctrl_seq
//   Timing/control sequencer for the 16-bit accumulator CPU. Steps through
//   fetch (T0-T1), decode (T2) and execute (T3-T6) and emits the register,
//   bus, ALU and memory strobes for each step. Strobes are combinational
//   from the current state and IR; their effect lands on the clock edge
//   that ends the state.
//   Ports:
//     CLK, RSTn        rising-edge clock, asynchronous active-low reset
//     run              level; starts execution from HALT
//     IR               current instruction from ir_reg
//     acZero/acSign    AC==0 / AC[15] flags;  drZero  DR==0 flag
//     irCtl..acCtl     {CLR,INR,LD} per register
//     busSel           bus source; aluOp  ALU function
//     eLD              load E from ALU carry
//     memRD/memWR      single-cycle memory strobes
//     halted, scT      status: in HALT, sequence counter (7 in HALT)
// ---------------------------------------------------------------------------
module ir_ctrl_seq
  import ir_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              run,
  input  logic [DATA_W-1:0] IR,
  input  logic              acZero,
  input  logic              acSign,
  input  logic              drZero,
  output logic [2:0]        irCtl,
  output logic [2:0]        arCtl,
  output logic [2:0]        pcCtl,
  output logic [2:0]        drCtl,
  output logic [2:0]        acCtl,
  output logic [2:0]        busSel,
  output logic [1:0]        aluOp,
  output logic              eLD,
  output logic              memRD,
  output logic              memWR,
  output logic              halted,
  output logic [2:0]        scT
);

  state_e              state_q, state_d;
  logic                indirect, mem_ref, reg_ref, io_ref;
  logic [6:0]          op_oh;
  logic [ADDR_W-1:0]   rr;

  ir_op_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dec (
    .ir_i        (IR),
    .indirect_o  (indirect),
    .mem_ref_o   (mem_ref),
    .reg_ref_o   (reg_ref),
    .io_ref_o    (io_ref),
    .op_onehot_o (op_oh),
    .rr_bits_o   (rr)
  );

  // NOTE: state is updated with non-blocking assignments so every reader
  // sees the pre-edge value; the async reset drops into HALT immediately,
  // which also kills any in-flight memWR through the output decode below.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_HALT;
    else       state_q <= state_d;
  end

  assign halted = (state_q == ST_HALT);
  assign scT    = state_q;

  // NOTE: every output and state_d gets a default before the case so no
  // path leaves a value unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    irCtl   = '0;
    arCtl   = '0;
    pcCtl   = '0;
    drCtl   = '0;
    acCtl   = '0;
    busSel  = BUS_NONE;
    aluOp   = ALU_AND;
    eLD     = 1'b0;
    memRD   = 1'b0;
    memWR   = 1'b0;

    case (state_q)
      ST_HALT: begin
        // RSTn gate keeps irCLR quiet while reset is held with run high.
        if (run && RSTn) begin
          irCtl[CTL_CLR] = 1'b1;
          state_d        = ST_T0;
        end
      end

      ST_T0: begin                       // AR <- PC
        busSel         = BUS_PC;
        arCtl[CTL_LD]  = 1'b1;
        state_d        = ST_T1;
      end

      ST_T1: begin                       // IR <- M[AR], PC <- PC+1
        memRD          = 1'b1;
        busSel         = BUS_MEM;
        irCtl[CTL_LD]  = 1'b1;
        pcCtl[CTL_INR] = 1'b1;
        state_d        = ST_T2;
      end

      ST_T2: begin                       // AR <- IR address field
        busSel         = BUS_IR;
        arCtl[CTL_LD]  = 1'b1;
        state_d        = ST_T3;
      end

      ST_T3: begin
        if (reg_ref) begin
          if      (|(rr & RR_CLA)) acCtl[CTL_CLR] = 1'b1;
          else if (|(rr & RR_CMA)) begin
            aluOp         = ALU_CMA;
            acCtl[CTL_LD] = 1'b1;
          end
          else if (|(rr & RR_INC)) acCtl[CTL_INR] = 1'b1;
          // All requested skip tests merge into a single PC increment.
          pcCtl[CTL_INR] = (|(rr & RR_SPA) && !acSign) ||
                           (|(rr & RR_SNA) &&  acSign) ||
                           (|(rr & RR_SZA) &&  acZero);
          state_d = |(rr & RR_HLT) ? ST_HALT : ST_T0;
        end else if (io_ref) begin
          state_d = ST_T0;
        end else begin
          if (indirect) begin            // AR <- M[AR]
            memRD         = 1'b1;
            busSel        = BUS_MEM;
            arCtl[CTL_LD] = 1'b1;
          end
          state_d = ST_T4;
        end
      end

      ST_T4: begin
        state_d = ST_T5;
        if (op_oh[OP_AND] || op_oh[OP_ADD] || op_oh[OP_LDA] || op_oh[OP_ISZ]) begin
          memRD         = 1'b1;
          busSel        = BUS_MEM;
          drCtl[CTL_LD] = 1'b1;
        end else if (op_oh[OP_STA]) begin
          busSel  = BUS_AC;
          memWR   = 1'b1;
          state_d = ST_T0;
        end else if (op_oh[OP_BUN]) begin
          busSel        = BUS_AR;
          pcCtl[CTL_LD] = 1'b1;
          state_d       = ST_T0;
        end else if (op_oh[OP_BSA]) begin // M[AR] <- PC, AR <- AR+1
          busSel         = BUS_PC;
          memWR          = 1'b1;
          arCtl[CTL_INR] = 1'b1;
        end
        // mem_ref is always true here; an opcode-7 word cannot reach T4.
        if (!mem_ref) state_d = ST_T0;
      end

      ST_T5: begin
        state_d = ST_T0;
        if (op_oh[OP_AND] || op_oh[OP_ADD] || op_oh[OP_LDA]) begin
          aluOp         = op_oh[OP_AND] ? ALU_AND :
                          op_oh[OP_ADD] ? ALU_ADD : ALU_PASS_DR;
          acCtl[CTL_LD] = 1'b1;
          eLD           = op_oh[OP_ADD];
        end else if (op_oh[OP_BSA]) begin
          busSel        = BUS_AR;
          pcCtl[CTL_LD] = 1'b1;
        end else if (op_oh[OP_ISZ]) begin
          drCtl[CTL_INR] = 1'b1;
          state_d        = ST_T6;
        end
      end

      ST_T6: begin                       // M[AR] <- DR, skip if it wrapped
        busSel         = BUS_DR;
        memWR          = 1'b1;
        pcCtl[CTL_INR] = drZero;
        state_d        = ST_T0;
      end

      default: state_d = ST_HALT;
    endcase
  end

endmodule
